chroma_mode_ctrl: RTL and testbench
===================================

# chroma_mode_ctrl

Sequencer for 8x8 chroma intra mode decision. It walks the residual generator through every available prediction mode (V, H, DC) for both chroma components, one 8-sample row per cycle. A single shared row-SAD datapath accumulates the cost per mode. It then picks the lowest-cost mode and hands it downstream over a valid/ready handshake. It replaces the all-parallel 64-sample-per-mode decision with a time-multiplexed schedule that shares one datapath and skips modes that are not available.

## Interface

Parameters: none.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  begin a block decision; sampled only in IDLE
- top_avail  in  1  top neighbours exist (enables V); latched at start
- left_avail  in  1  left neighbours exist (enables H); latched at start
- rd_en  out  1  residual row read request
- rd_mode  out  2  mode of request: 0=V, 1=H, 2=DC
- rd_comp  out  1  component of request: 0=Cb, 1=Cr
- rd_row  out  3  row index 0..7
- row_res  in  64  residual row returned exactly 1 cycle after rd_en; sample c at [8c+7:8c], signed two's complement
- busy  out  1  high from first issued read until handshake completes
- out_valid  out  1  decision available; held until accepted
- out_ready  in  1  downstream accepts the decision
- mode  out  3  chosen mode (0=V, 1=H, 2=DC)
- sad  out  15  SAD of chosen mode over Cb+Cr (max 16384)

## Operation

- States: IDLE, RUN, DRAIN, DECIDE, DONE.
- IDLE:
  - On start=1, latch availability. Enabled set = {V if top_avail, H if left_avail, DC always}.
  - Clear the three accumulators. Go to RUN.
  - Otherwise remain in IDLE.
- RUN: rd_en=1 every cycle. Issue order:
  - mode ascending over the enabled set;
  - within a mode, comp 0 then comp 1;
  - within a comp, row 0..7.
  - 16 reads per enabled mode, issued back to back with no bubble between modes.
  - After the final read, go to DRAIN.
- Datapath, for each returned row:
  - per-sample |x| computed in 9 bits, so |-128| = 128 (no wrap);
  - row sum is 11 bits;
  - row sum is added to the accumulator of the mode carried in a 1-cycle-delayed copy of rd_mode.
  - Accumulators are 15 bits and cannot overflow.
- DRAIN: accumulate the last row. Go to DECIDE.
- DECIDE: minimum over enabled modes only.
  - Ties resolve to the lower mode number.
  - Register mode and sad. Go to DONE.
- DONE:
  - out_valid=1; mode and sad are stable.
  - out_valid && out_ready: go to IDLE, out_valid drops next cycle.
- start outside IDLE is ignored. start in the same cycle as the DONE handshake is ignored.
- Changes on top_avail/left_avail after start have no effect.

## Timing

- Reset (reset=0 at an edge) forces IDLE from any state, including mid-RUN. All outputs read 0 after that edge: rd_en, rd_mode, rd_comp, rd_row, busy, out_valid, mode, sad. In-flight data is discarded.
- Define start sampled at cycle 0 and N = number of enabled modes (1..3):
  - reads occur in cycles 1..16N;
  - DRAIN in cycle 16N+1;
  - DECIDE in cycle 16N+2;
  - out_valid first high in cycle 16N+3.
- N=3: out_valid at cycle 51. N=1: out_valid at cycle 19.
- busy is high in cycles 1 through the handshake cycle.
- rd_mode/rd_comp/rd_row are valid only while rd_en=1. They are 0 otherwise.
- Earliest next start is the cycle after the handshake.

## Configuration

- CHROMA_EARLY_TERM_EN defined: early termination is enabled.
  - A mode aborts when its running accumulator, after adding a row, is strictly greater than the best finished SAD so far.
  - Remaining reads of the aborted mode are skipped. Issue jumps to the next enabled mode, or to DRAIN if none remain.
  - The one read already in flight for the aborted mode is discarded.
  - An aborted mode is never selected.
  - Latency becomes ≤ 16N+3.
- CHROMA_EARLY_TERM_EN undefined: all 16N reads are always issued, and latency is exactly 16N+3.

## Test plan

- All-zero residuals, both avail: out_valid at cycle 51, mode=0, sad=0, 48 reads in the specified order.
- V rows all 10, H rows all 5, DC rows all 1, both avail: mode=2, sad=128; per-mode sums are V=1280, H=640.
- All samples -128 in every mode, both avail: sad=16384 with no wrap; mode=0 from the tie rule.
- top_avail=0, left_avail=0: only 16 DC reads, out_valid at cycle 19, mode=2.
- out_ready held low 10 cycles after out_valid, start pulsed meanwhile: outputs stable, start ignored; accepted on out_ready, IDLE next cycle.
- reset low at cycle 20 mid-RUN: all outputs 0 next cycle. A new start runs cleanly with no residue from the aborted accumulators. With CHROMA_EARLY_TERM_EN and V=all 0, H=all 1: the H read stream stops after its first row, still mode=0, sad=0.

Source files
------------

// File: rtl/chroma_mode_ctrl.sv
// chroma_mode_ctrl: time-multiplexed 8x8 chroma intra mode decision.
// Walks V/H/DC (only the available ones) over Cb then Cr, one row per cycle,
// accumulates a row-SAD per mode through one shared datapath, then hands the
// cheapest mode downstream over valid/ready.
// Optional feature macro: CHROMA_EARLY_TERM_EN (abort modes already losing).
module chroma_mode_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        top_avail,
  input  logic        left_avail,
  output logic        rd_en,
  output logic [1:0]  rd_mode,
  output logic        rd_comp,
  output logic [2:0]  rd_row,
  input  logic [63:0] row_res,
  output logic        busy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  mode,
  output logic [14:0] sad
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_DRAIN  = 3'd2,
    S_DECIDE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Magnitude of one signed sample, widened to 9 bits so -128 maps to 128.
  function automatic logic [8:0] abs_sample(input logic [7:0] s);
    logic [8:0] ext;
    ext = {s[7], s};
    if (s[7]) begin
      abs_sample = 9'd0 - ext;
    end else begin
      abs_sample = ext;
    end
  endfunction

  // Sum of the eight sample magnitudes of one row (max 1024, fits 11 bits).
  function automatic logic [10:0] row_abs_sum(input logic [63:0] row);
    logic [10:0] acc;
    acc = 11'd0;
    for (int c = 0; c < 8; c++) begin
      acc = acc + {2'b00, abs_sample(row[8*c +: 8])};
    end
    return acc;
  endfunction

  // Next enabled mode after m: {exists, mode}. DC is always enabled and last.
  function automatic logic [2:0] next_mode(input logic [1:0] m, input logic [1:0] en);
    logic [2:0] r;
    case (m)
      2'd0:    r = en[1] ? {1'b1, 2'd1} : {1'b1, 2'd2};
      2'd1:    r = {1'b1, 2'd2};
      default: r = {1'b0, 2'd0};
    endcase
    return r;
  endfunction

  state_t      r_state;
  logic [1:0]  r_en;        // bit0: V enabled, bit1: H enabled
  logic [14:0] r_acc_v;
  logic [14:0] r_acc_h;
  logic [14:0] r_acc_dc;
  logic [2:0]  r_abort;     // per-mode abort flags (only ever set with early termination)
  logic        r_dvalid;    // row_res carries data this cycle
  logic [1:0]  r_dmode;     // mode of the row on row_res
  logic        r_rd_en;
  logic [1:0]  r_rd_mode;
  logic        r_rd_comp;
  logic [2:0]  r_rd_row;
  logic        r_busy;
  logic        r_out_valid;
  logic [2:0]  r_mode;
  logic [14:0] r_sad;
`ifdef CHROMA_EARLY_TERM_EN
  logic        r_dcomp;
  logic [2:0]  r_drow;
  logic [14:0] r_best;      // SAD of the best mode finished so far
  logic        r_best_vld;
  logic        w_finish_now;
`endif

  logic [10:0] w_row_sum;
  logic [14:0] w_acc_sel;
  logic [14:0] w_acc_new;
  logic        w_acc_do;
  logic        w_abort_now;
  logic        w_skip;
  logic        w_jump;
  logic [2:0]  w_nm;
  logic [1:0]  w_first;
  logic [2:0]  w_cand;
  logic        w_pick_h;
  logic        w_s1_found;
  logic [1:0]  w_s1_mode;
  logic [14:0] w_s1_sad;
  logic        w_pick_v;
  logic [1:0]  w_dec_mode;
  logic [14:0] w_dec_sad;

  assign w_row_sum = row_abs_sum(row_res);

  // Select the accumulator belonging to the mode of the returning row.
  always_comb begin
    w_acc_sel = r_acc_dc;
    case (r_dmode)
      2'd0:    w_acc_sel = r_acc_v;
      2'd1:    w_acc_sel = r_acc_h;
      default: w_acc_sel = r_acc_dc;
    endcase
  end

  assign w_acc_new = w_acc_sel + {4'd0, w_row_sum};
  // Rows of an aborted mode (the one still in flight) are dropped.
  assign w_acc_do  = r_dvalid & ~r_abort[r_dmode];

`ifdef CHROMA_EARLY_TERM_EN
  assign w_abort_now  = w_acc_do & r_best_vld & (w_acc_new > r_best);
  assign w_finish_now = w_acc_do & ~w_abort_now & r_dcomp & (r_drow == 3'd7);
`else
  assign w_abort_now  = 1'b0;
`endif

  // Issue sequencing: jump to the next mode at the end of a mode, or early when
  // the mode currently being issued has just been aborted.
  assign w_nm    = next_mode(r_rd_mode, r_en);
  assign w_skip  = w_abort_now & r_rd_en & (r_rd_mode == r_dmode);
  assign w_jump  = (r_rd_comp & (r_rd_row == 3'd7)) | w_skip;
  assign w_first = top_avail ? 2'd0 : (left_avail ? 2'd1 : 2'd2);

  // Minimum search from DC down to V with <= so ties settle on the lower mode.
  assign w_cand     = {1'b1, r_en[1], r_en[0]} & ~r_abort;
  assign w_pick_h   = w_cand[1] & (~w_cand[2] | (r_acc_h <= r_acc_dc));
  assign w_s1_found = w_cand[2] | w_cand[1];
  assign w_s1_mode  = w_pick_h ? 2'd1 : 2'd2;
  assign w_s1_sad   = w_pick_h ? r_acc_h : r_acc_dc;
  assign w_pick_v   = w_cand[0] & (~w_s1_found | (r_acc_v <= w_s1_sad));
  assign w_dec_mode = w_pick_v ? 2'd0 : w_s1_mode;
  assign w_dec_sad  = w_pick_v ? r_acc_v : w_s1_sad;

  // Control FSM, read issue, accumulation and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_en        <= 2'b00;
      r_acc_v     <= 15'd0;
      r_acc_h     <= 15'd0;
      r_acc_dc    <= 15'd0;
      r_abort     <= 3'b000;
      r_dvalid    <= 1'b0;
      r_dmode     <= 2'd0;
      r_rd_en     <= 1'b0;
      r_rd_mode   <= 2'd0;
      r_rd_comp   <= 1'b0;
      r_rd_row    <= 3'd0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_mode      <= 3'd0;
      r_sad       <= 15'd0;
`ifdef CHROMA_EARLY_TERM_EN
      r_dcomp     <= 1'b0;
      r_drow      <= 3'd0;
      r_best      <= 15'd0;
      r_best_vld  <= 1'b0;
`endif
    end else begin
      r_dvalid <= r_rd_en;
      r_dmode  <= r_rd_mode;
`ifdef CHROMA_EARLY_TERM_EN
      r_dcomp  <= r_rd_comp;
      r_drow   <= r_rd_row;
      if (w_abort_now) begin
        r_abort[r_dmode] <= 1'b1;
      end
      if (w_finish_now) begin
        r_best     <= w_acc_new;
        r_best_vld <= 1'b1;
      end
`endif
      if (w_acc_do && !w_abort_now) begin
        case (r_dmode)
          2'd0:    r_acc_v  <= w_acc_new;
          2'd1:    r_acc_h  <= w_acc_new;
          default: r_acc_dc <= w_acc_new;
        endcase
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_en      <= {left_avail, top_avail};
            r_acc_v   <= 15'd0;
            r_acc_h   <= 15'd0;
            r_acc_dc  <= 15'd0;
            r_abort   <= 3'b000;
            r_busy    <= 1'b1;
            r_rd_en   <= 1'b1;
            r_rd_mode <= w_first;
            r_rd_comp <= 1'b0;
            r_rd_row  <= 3'd0;
            r_state   <= S_RUN;
`ifdef CHROMA_EARLY_TERM_EN
            r_best     <= 15'd0;
            r_best_vld <= 1'b0;
`endif
          end
        end
        S_RUN: begin
          if (w_jump) begin
            if (w_nm[2]) begin
              r_rd_mode <= w_nm[1:0];
              r_rd_comp <= 1'b0;
              r_rd_row  <= 3'd0;
            end else begin
              r_rd_en   <= 1'b0;
              r_rd_mode <= 2'd0;
              r_rd_comp <= 1'b0;
              r_rd_row  <= 3'd0;
              r_state   <= S_DRAIN;
            end
          end else if (r_rd_row == 3'd7) begin
            r_rd_comp <= 1'b1;
            r_rd_row  <= 3'd0;
          end else begin
            r_rd_row  <= r_rd_row + 3'd1;
          end
        end
        S_DRAIN: begin
          r_state <= S_DECIDE;
        end
        S_DECIDE: begin
          r_mode      <= {1'b0, w_dec_mode};
          r_sad       <= w_dec_sad;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rd_en     = r_rd_en;
  assign rd_mode   = r_rd_mode;
  assign rd_comp   = r_rd_comp;
  assign rd_row    = r_rd_row;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign mode      = r_mode;
  assign sad       = r_sad;

endmodule

// File: tb/tb_chroma_mode_ctrl.sv
// Directed self-checking bench for chroma_mode_ctrl.
module tb_chroma_mode_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        top_avail;
  logic        left_avail;
  logic        rd_en;
  logic [1:0]  rd_mode;
  logic        rd_comp;
  logic [2:0]  rd_row;
  logic [63:0] row_res;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  mode;
  logic [14:0] sad;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int mn = 0;
  logic [1:0]  ml [0:2];
  logic [63:0] pat [0:2];
  logic        order_on = 1'b1;
  logic        timing_on = 1'b1;

  always #5 clk = ~clk;

  chroma_mode_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .top_avail(top_avail),
    .left_avail(left_avail), .rd_en(rd_en), .rd_mode(rd_mode),
    .rd_comp(rd_comp), .rd_row(rd_row), .row_res(row_res), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .mode(mode), .sad(sad)
  );

  function automatic logic [63:0] rep(input logic [7:0] b);
    return {8{b}};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected {mode,comp,row} of the idx-th read of the current block.
  function automatic logic [31:0] exp_rd(input int idx);
    logic [1:0] m;
    logic       c;
    logic [2:0] r;
    if (idx / 16 >= mn) return 32'hFFFF_FFFF;
    m = ml[idx / 16];
    c = ((idx / 8) % 2) == 1;
    r = 3'(idx % 8);
    return {26'd0, m, c, r};
  endfunction

  // One clock: feed back the row requested last cycle, then check the read port.
  task automatic tick();
    logic       pe;
    logic [1:0] pm;
    pe = rd_en;
    pm = rd_mode;
    @(posedge clk);
    #1;
    cyc++;
    row_res = (pe === 1'b1) ? pat[pm] : 64'd0;
    if (rd_en === 1'b1) begin
      if (order_on) chk("rd_order", {26'd0, rd_mode, rd_comp, rd_row}, exp_rd(rd_cnt));
      rd_cnt++;
    end else begin
      chk("rd_idle_zero", {26'd0, rd_mode, rd_comp, rd_row}, 32'd0);
    end
  endtask

  task automatic set_modes(input logic t, input logic l);
    mn = 0;
    if (t) begin ml[mn] = 2'd0; mn++; end
    if (l) begin ml[mn] = 2'd1; mn++; end
    ml[mn] = 2'd2;
    mn++;
  endtask

  task automatic run_block(input string tag, input logic t, input logic l,
                           input logic [2:0] emode, input logic [14:0] esad, input int hold);
    int lat;
    set_modes(t, l);
    rd_cnt = 0;
    top_avail = t;
    left_avail = l;
    start = 1'b1;
    tick();
    start = 1'b0;
    top_avail = ~t;
    left_avail = ~l;
    chk({tag, "_busy_c1"}, {31'd0, busy}, 32'd1);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
    if (timing_on) begin
      chk({tag, "_latency"}, lat, 16 * mn + 3);
      chk({tag, "_reads"}, rd_cnt, 16 * mn);
    end
    chk({tag, "_mode"}, {29'd0, mode}, {29'd0, emode});
    chk({tag, "_sad"}, {17'd0, sad}, {17'd0, esad});
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    for (int h = 0; h < hold; h++) begin
      start = 1'b1;
      tick();
      chk({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_hold_mode"}, {29'd0, mode}, {29'd0, emode});
      chk({tag, "_hold_sad"}, {17'd0, sad}, {17'd0, esad});
      chk({tag, "_hold_rd"}, {31'd0, rd_en}, 32'd0);
    end
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    out_ready = 1'b0;
    start = 1'b0;
    chk({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_busy_drop"}, {31'd0, busy}, 32'd0);
    chk({tag, "_no_restart"}, {31'd0, rd_en}, 32'd0);
    tick();
    chk({tag, "_idle"}, {31'd0, rd_en}, 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    top_avail = 1'b0;
    left_avail = 1'b0;
    out_ready = 1'b0;
    row_res = 64'd0;
    pat[0] = 64'd0;
    pat[1] = 64'd0;
    pat[2] = 64'd0;
    tick();
    tick();
    chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mode", {29'd0, mode}, 32'd0);
    chk("rst_sad", {17'd0, sad}, 32'd0);
    reset = 1'b1;
    tick();

    // All zero residuals: V wins the three-way tie.
    run_block("zero", 1'b1, 1'b1, 3'd0, 15'd0, 0);

    // V=10 (1280), H=5 (640), DC=1 (128).
    pat[0] = rep(8'd10);
    pat[1] = rep(8'd5);
    pat[2] = rep(8'd1);
    run_block("vhd", 1'b1, 1'b1, 3'd2, 15'd128, 0);

    // All -128: 16384 each with no wrap, tie goes to V.
    pat[0] = rep(8'h80);
    pat[1] = rep(8'h80);
    pat[2] = rep(8'h80);
    run_block("neg128", 1'b1, 1'b1, 3'd0, 15'd16384, 0);

    // Nothing available: DC only, 16 reads of |3| rows.
    pat[2] = rep(8'd3);
    run_block("dconly", 1'b0, 1'b0, 3'd2, 15'd384, 0);

    // H=+3 vs DC=-3 tie (384); held 10 cycles with start pulses.
    pat[1] = rep(8'd3);
    pat[2] = rep(8'hFD);
    run_block("hold", 1'b0, 1'b1, 3'd1, 15'd384, 10);

    // V=-64 (8192) vs DC mixed-sign row (388 per row -> 6208).
    pat[0] = rep(8'hC0);
    pat[2] = 64'h8102_FE00_FF01_7F80;
    run_block("mixed", 1'b1, 1'b0, 3'd2, 15'd6208, 0);

    // Reset in the middle of RUN, then a clean restart.
    set_modes(1'b1, 1'b1);
    rd_cnt = 0;
    pat[0] = rep(8'd50);
    pat[1] = rep(8'd60);
    pat[2] = rep(8'd70);
    top_avail = 1'b1;
    left_avail = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < 20; k++) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mid_rst_rd_en", {31'd0, rd_en}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_mode", {29'd0, mode}, 32'd0);
    chk("mid_rst_sad", {17'd0, sad}, 32'd0);
    tick();
    chk("post_rst_idle", {31'd0, rd_en}, 32'd0);

    pat[0] = rep(8'd0);
    pat[1] = rep(8'd1);
    pat[2] = rep(8'd1);
`ifdef CHROMA_EARLY_TERM_EN
    timing_on = 1'b0;
    order_on = 1'b0;
`endif
    run_block("restart", 1'b1, 1'b1, 3'd0, 15'd0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
